// File: rtl/code_decoder.sv
// Sequential 2-to-4 decoder: buffers incoming priority codes in a small FIFO and drives each
// decoded one-hot value on dec_out for HOLD cycles, back-to-back when codes are queued.
module code_decoder #(
    parameter int unsigned HOLD  = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] code_in,
    output logic       in_ready,
    output logic [3:0] dec_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] level
);

    localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  HoldLast = 4'(HOLD - 1);
    localparam logic        HoldOne  = (HOLD == 1);

    typedef enum logic [0:0] {StIdle, StDrive} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    mem [DEPTH];
    logic [1:0]    head;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Readiness looks only at current occupancy; a same-cycle pop does not free a slot.
    assign in_ready = !rst && (level < 4'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    // Pop whenever the FSM is about to start a new code: from idle, or at the end of a hold.
    assign pop      = (level != 4'd0) && ((state == StIdle) || (cnt == 4'd0));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= code_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            cnt     <= 4'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= 4'd0;
            dec_out <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            level <= level + 4'(push) - 4'(pop);

            // done is registered so it lines up with the final cycle that cnt reads zero.
            unique case (state)
                StIdle: begin
                    if (pop) begin
                        dec_out <= 4'b0001 << head;
                        cnt     <= HoldLast;
                        done    <= HoldOne;
                        busy    <= 1'b1;
                        state   <= StDrive;
                    end else begin
                        dec_out <= 4'd0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                StDrive: begin
                    if (cnt != 4'd0) begin
                        cnt  <= cnt - 4'd1;
                        done <= (cnt == 4'd1);
                    end else if (pop) begin
                        dec_out <= 4'b0001 << head;
                        cnt     <= HoldLast;
                        done    <= HoldOne;
                    end else begin
                        dec_out <= 4'd0;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                        state   <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_code_decoder.sv
// Directed bench for code_decoder: HOLD=3/DEPTH=2 instance plus a HOLD=1 streaming instance.
module tb_code_decoder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] code_in;
    logic       in_ready;
    logic [3:0] dec_out;
    logic       busy;
    logic       done;
    logic [3:0] level;

    logic       in_valid1;
    logic [1:0] code_in1;
    logic       in_ready1;
    logic [3:0] dec_out1;
    logic       busy1;
    logic       done1;
    logic [3:0] level1;

    int checks = 0;
    int errors = 0;

    code_decoder #(.HOLD(3), .DEPTH(2)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .code_in  (code_in),
        .in_ready (in_ready),
        .dec_out  (dec_out),
        .busy     (busy),
        .done     (done),
        .level    (level)
    );

    code_decoder #(.HOLD(1), .DEPTH(2)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid1),
        .code_in  (code_in1),
        .in_ready (in_ready1),
        .dec_out  (dec_out1),
        .busy     (busy1),
        .done     (done1),
        .level    (level1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_main(input string tag, input logic [3:0] e_dec, input logic e_busy,
                               input logic e_done, input logic [3:0] e_level, input logic e_rdy);
        check4({tag, ".dec_out"}, dec_out, e_dec);
        check1({tag, ".busy"}, busy, e_busy);
        check1({tag, ".done"}, done, e_done);
        check4({tag, ".level"}, level, e_level);
        check1({tag, ".in_ready"}, in_ready, e_rdy);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        code_in   = 2'd0;
        in_valid1 = 1'b0;
        code_in1  = 2'd0;

        // Reset state
        tick();
        tick();
        expect_main("reset", 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
        check4("reset.dut1_level", level1, 4'd0);
        rst = 1'b0;
        #1;
        check1("release.in_ready", in_ready, 1'b1);

        // Single code 2, HOLD=3
        in_valid = 1'b1;
        code_in  = 2'd2;
        tick();
        expect_main("single.push", 4'b0000, 1'b0, 1'b0, 4'd1, 1'b1);
        in_valid = 1'b0;
        tick();
        expect_main("single.c1", 4'b0100, 1'b1, 1'b0, 4'd0, 1'b1);
        tick();
        expect_main("single.c2", 4'b0100, 1'b1, 1'b0, 4'd0, 1'b1);
        tick();
        expect_main("single.c3", 4'b0100, 1'b1, 1'b1, 4'd0, 1'b1);
        tick();
        expect_main("single.after", 4'b0000, 1'b0, 1'b0, 4'd0, 1'b1);

        // Codes 0,1,3,2 with valid held: fills the FIFO and stalls on ready
        in_valid = 1'b1;
        code_in  = 2'd0;
        tick();
        expect_main("seq.e1", 4'b0000, 1'b0, 1'b0, 4'd1, 1'b1);
        code_in = 2'd1;
        tick();
        expect_main("seq.e2", 4'b0001, 1'b1, 1'b0, 4'd1, 1'b1);
        code_in = 2'd3;
        tick();
        expect_main("seq.e3", 4'b0001, 1'b1, 1'b0, 4'd2, 1'b0);
        code_in = 2'd2;
        tick();
        expect_main("seq.e4_full_pop", 4'b0001, 1'b1, 1'b1, 4'd2, 1'b0);
        tick();
        expect_main("seq.e5_ready_back", 4'b0010, 1'b1, 1'b0, 4'd1, 1'b1);
        tick();
        expect_main("seq.e6", 4'b0010, 1'b1, 1'b0, 4'd2, 1'b0);
        in_valid = 1'b0;
        tick();
        expect_main("seq.e7", 4'b0010, 1'b1, 1'b1, 4'd2, 1'b0);
        tick();
        expect_main("seq.e8", 4'b1000, 1'b1, 1'b0, 4'd1, 1'b1);
        tick();
        expect_main("seq.e9", 4'b1000, 1'b1, 1'b0, 4'd1, 1'b1);
        tick();
        expect_main("seq.e10", 4'b1000, 1'b1, 1'b1, 4'd1, 1'b1);
        tick();
        expect_main("seq.e11", 4'b0100, 1'b1, 1'b0, 4'd0, 1'b1);
        tick();
        expect_main("seq.e12", 4'b0100, 1'b1, 1'b0, 4'd0, 1'b1);
        tick();
        expect_main("seq.e13", 4'b0100, 1'b1, 1'b1, 4'd0, 1'b1);
        tick();
        expect_main("seq.e14", 4'b0000, 1'b0, 1'b0, 4'd0, 1'b1);

        // Reset mid-drive with two codes buffered
        in_valid = 1'b1;
        code_in  = 2'd1;
        tick();
        expect_main("rmid.e1", 4'b0000, 1'b0, 1'b0, 4'd1, 1'b1);
        code_in = 2'd2;
        tick();
        expect_main("rmid.e2", 4'b0010, 1'b1, 1'b0, 4'd1, 1'b1);
        code_in = 2'd3;
        tick();
        expect_main("rmid.e3", 4'b0010, 1'b1, 1'b0, 4'd2, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        expect_main("rmid.reset", 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        tick();
        expect_main("rmid.flushed", 4'b0000, 1'b0, 1'b0, 4'd0, 1'b1);
        in_valid = 1'b1;
        code_in  = 2'd3;
        tick();
        expect_main("rmid.push", 4'b0000, 1'b0, 1'b0, 4'd1, 1'b1);
        in_valid = 1'b0;
        tick();
        expect_main("rmid.c1", 4'b1000, 1'b1, 1'b0, 4'd0, 1'b1);
        tick();
        expect_main("rmid.c2", 4'b1000, 1'b1, 1'b0, 4'd0, 1'b1);
        tick();
        expect_main("rmid.c3", 4'b1000, 1'b1, 1'b1, 4'd0, 1'b1);
        tick();
        expect_main("rmid.after", 4'b0000, 1'b0, 1'b0, 4'd0, 1'b1);

        // HOLD=1 streaming: 0,1,2,3 repeated, one code decoded per cycle
        in_valid1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            code_in1 = 2'(i % 4);
            tick();
            check4($sformatf("stream.level[%0d]", i), level1, 4'd1);
            if (i >= 1) begin
                check4($sformatf("stream.dec[%0d]", i), dec_out1, 4'b0001 << ((i - 1) % 4));
                check1($sformatf("stream.done[%0d]", i), done1, 1'b1);
                check1($sformatf("stream.ready[%0d]", i), in_ready1, 1'b1);
            end
        end
        in_valid1 = 1'b0;
        tick();
        check4("stream.last_dec", dec_out1, 4'b1000);
        check4("stream.last_level", level1, 4'd0);
        tick();
        check4("stream.idle_dec", dec_out1, 4'b0000);
        check1("stream.idle_busy", busy1, 1'b0);
        check1("stream.idle_done", done1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
